uart_frame_parser: RTL and testbench

- Sits directly downstream of uart_rx and consumes its uart_rxd/rx_done byte stream.
- Recognises fixed-format frames: HDR0, HDR1, LEN, LEN payload bytes, CHK.
- Buffers the payload internally and verifies the checksum.
- Releases the payload to the downstream consumer (uart_tx path or user logic) only after the frame checks good, using a valid/ready handshake.

---
 rtl/uart_frame_parser.sv | 158 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses 55 AA LEN payload CHK frames from a uart_rx byte stream,
// buffers the payload, checks the additive checksum (LEN + payload, mod 256) and only
// then streams the payload out over a valid/ready handshake.
// Ports: sys_clk/sys_rst (sync, active high); uart_rxd/rx_done byte input;
// m_data/m_valid/m_ready/m_last payload output; frame_ok/frame_err/overrun pulses;
// err_code holds the cause of the most recent error.
module uart_frame_parser #(
  parameter logic [7:0] HDR0           = 8'h55,
  parameter logic [7:0] HDR1           = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 5000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] uart_rxd,
  input  logic       rx_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  // gap_cnt value on the idle cycle that completes TIMEOUT_CYCLES idle cycles
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [2:0] S_HDR0    = 3'd0;
  localparam logic [2:0] S_HDR1    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;

  logic [2:0]    state;
  logic [7:0]    len_r;
  logic [7:0]    sum;
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    pay_buf [MAX_LEN];

  logic in_frame;
  logic timeout_hit;
  logic send;

  assign in_frame    = (state == S_HDR1) || (state == S_LEN) ||
                       (state == S_PAYLOAD) || (state == S_CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !rx_done && (gap_cnt == GAP_LAST);
  assign send        = (state == S_SEND);

  // Output side is purely a view of the SEND state, so m_valid rises together
  // with the registered frame_ok pulse and drops the cycle after the last beat.
  assign m_valid = send;
  assign m_data  = send ? pay_buf[rd_ptr[AW-1:0]] : 8'h00;
  assign m_last  = send && (rd_ptr == len_r - 8'd1);

  // Payload storage has no reset; only entries below len_r are ever read.
  always_ff @(posedge sys_clk) begin
    if (state == S_PAYLOAD && rx_done) begin
      pay_buf[wr_ptr[AW-1:0]] <= uart_rxd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_HDR0;
      len_r     <= 8'h00;
      sum       <= 8'h00;
      wr_ptr    <= 8'h00;
      rd_ptr    <= 8'h00;
      gap_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (!in_frame || rx_done || timeout_hit) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= S_HDR0;
      end else begin
        case (state)
          S_HDR0: begin
            if (rx_done && uart_rxd == HDR0) state <= S_HDR1;
          end
          S_HDR1: begin
            if (rx_done) begin
              if (uart_rxd == HDR1)      state <= S_LEN;
              else if (uart_rxd != HDR0) state <= S_HDR0;
              // a repeated HDR0 keeps us waiting for HDR1
            end
          end
          S_LEN: begin
            if (rx_done) begin
              if (uart_rxd == 8'h00 || uart_rxd > MAX_LEN8) begin
                frame_err <= 1'b1;
                err_code  <= 2'd1;
                state     <= S_HDR0;
              end else begin
                len_r  <= uart_rxd;
                sum    <= uart_rxd;
                wr_ptr <= 8'h00;
                state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (rx_done) begin
              sum    <= sum + uart_rxd;
              wr_ptr <= wr_ptr + 8'd1;
              if (wr_ptr == len_r - 8'd1) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (rx_done) begin
              if (uart_rxd == sum) begin
                frame_ok <= 1'b1;
                rd_ptr   <= 8'h00;
                state    <= S_SEND;
              end else begin
                frame_err <= 1'b1;
                err_code  <= 2'd2;
                state     <= S_HDR0;
              end
            end
          end
          S_SEND: begin
            // Bytes arriving while draining are dropped, never parsed.
            if (rx_done) overrun <= 1'b1;
            if (m_ready) begin
              rd_ptr <= rd_ptr + 8'd1;
              if (m_last) state <= S_HDR0;
            end
          end
          default: state <= S_HDR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] uart_rxd;
  logic       rx_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  uart_frame_parser dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .rx_done  (rx_done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int         tests_run = 0;
  int         fails     = 0;
  beat_t      exp_q[$];
  logic [7:0] pay[$];
  int         ok_cnt = 0, err_cnt = 0, ov_cnt = 0, beat_cnt = 0;
  bit         bp_en  = 0;
  int         bp_ph  = 0;

  // Scoreboard / protocol monitor, sampling on the falling edge.
  initial begin
    beat_t      e;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        if (hold_prev) begin
          tests_run++;
          if ({m_valid, m_data, m_last} !== {1'b1, hold_data, hold_last}) begin
            fails++;
            $display("FAIL hold_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                     m_valid, m_data, m_last, hold_data, hold_last);
          end
        end
        if (m_valid && m_ready) begin
          beat_cnt++;
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got d=%h l=%b, want no beat", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last} !== {e.d, e.l}) begin
              fails++;
              $display("FAIL beat_data: got d=%h l=%b, want d=%h l=%b", m_data, m_last, e.d, e.l);
            end
          end
        end
        if (frame_ok || frame_err) begin
          tests_run++;
          if (frame_ok && frame_err) begin
            fails++;
            $display("FAIL ok_err_exclusive: got ok=1 err=1, want only one");
          end
        end
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (overrun)   ov_cnt++;
      end
      hold_prev = m_valid && !m_ready && !sys_rst;
      hold_data = m_data;
      hold_last = m_last;
    end
  end

  // Backpressure pattern 1,0,0,1,0,0,... when enabled.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (bp_en) begin
        m_ready = (bp_ph % 3 == 0);
        bp_ph++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, want completion");
    $fatal(1, "watchdog");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_rxd = b;
    rx_done  = 1'b1;
    @(posedge sys_clk); #1;
    rx_done  = 1'b0;
    uart_rxd = 8'h00;
    repeat (gap) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  function automatic logic [7:0] chk_of();
    logic [7:0] s;
    s = 8'(pay.size());
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  // Sends header, LEN, pay[] and a correct checksum; expected beats are queued.
  task automatic send_good_frame(input int last_gap);
    send_byte(8'h55, 1);
    send_byte(8'hAA, 1);
    send_byte(8'(pay.size()), 1);
    foreach (pay[i]) begin
      exp_q.push_back('{d: pay[i], l: (i == pay.size() - 1)});
      send_byte(pay[i], 1);
    end
    send_byte(chk_of(), last_gap);
  endtask

  task automatic wait_drain(output bit done);
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && m_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic check_drained(input string name);
    bit done;
    wait_drain(done);
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL %s_drain: got %0d beats pending m_valid=%b, want 0 pending m_valid=0",
               name, exp_q.size(), m_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    sys_rst  = 1'b1;
    rx_done  = 1'b0;
    uart_rxd = 8'h00;
    m_ready  = 1'b0;
    idle(3);
    tests_run++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, err_code, overrun} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b ok=%b err=%b code=%0d ov=%b, want all 0",
               m_valid, m_data, m_last, frame_ok, frame_err, err_code, overrun);
    end
    sys_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    int ok0 = ok_cnt, err0 = err_cnt, b0 = beat_cnt;
    m_ready = 1'b1;
    pay = '{8'h11, 8'h22, 8'h33};
    send_good_frame(0);
    tests_run++;
    if ({frame_ok, m_valid, m_data, m_last} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
      fails++;
      $display("FAIL good_first_cycle: got ok=%b v=%b d=%h l=%b, want ok=1 v=1 d=11 l=0",
               frame_ok, m_valid, m_data, m_last);
    end
    idle(1);
    tests_run++;
    if (frame_ok !== 1'b0) begin
      fails++;
      $display("FAIL good_ok_width: got frame_ok=%b, want 0 on second cycle", frame_ok);
    end
    idle(2);
    tests_run++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL good_throughput: got m_valid=%b pending=%0d after 3 cycles, want 0/0",
               m_valid, exp_q.size());
    end
    check_drained("good");
    tests_run++;
    if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0 || beat_cnt - b0 != 3 || err_code !== 2'd0) begin
      fails++;
      $display("FAIL good_counts: got ok=%0d err=%0d beats=%0d code=%0d, want 1 0 3 0",
               ok_cnt - ok0, err_cnt - err0, beat_cnt - b0, err_code);
    end
  endtask

  task automatic test_backpressure();
    int ok0 = ok_cnt, b0 = beat_cnt;
    m_ready = 1'b0;
    pay = '{8'h11, 8'h22, 8'h33};
    send_good_frame(0);
    bp_ph = 0;
    bp_en = 1;
    check_drained("bp");
    bp_en = 0;
    m_ready = 1'b1;
    tests_run++;
    if (ok_cnt - ok0 != 1 || beat_cnt - b0 != 3) begin
      fails++;
      $display("FAIL bp_counts: got ok=%0d beats=%0d, want 1 3", ok_cnt - ok0, beat_cnt - b0);
    end
  endtask

  task automatic test_bad_frames();
    int err0 = err_cnt, b0 = beat_cnt, ok0 = ok_cnt;
    m_ready = 1'b1;
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1);
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h00, 0);
    tests_run++;
    if ({frame_err, err_code, m_valid} !== {1'b1, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL bad_chk: got err=%b code=%0d v=%b, want err=1 code=2 v=0",
               frame_err, err_code, m_valid);
    end
    idle(2);
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h00, 0);
    tests_run++;
    if ({frame_err, err_code} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL bad_len_zero: got err=%b code=%0d, want err=1 code=1", frame_err, err_code);
    end
    idle(2);
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h11, 0);
    tests_run++;
    if ({frame_err, err_code} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL bad_len_big: got err=%b code=%0d, want err=1 code=1", frame_err, err_code);
    end
    idle(3);
    tests_run++;
    if (err_cnt - err0 != 3 || beat_cnt - b0 != 0 || ok_cnt - ok0 != 0) begin
      fails++;
      $display("FAIL bad_counts: got err=%0d beats=%0d ok=%0d, want 3 0 0",
               err_cnt - err0, beat_cnt - b0, ok_cnt - ok0);
    end
  endtask

  task automatic test_resync();
    int ok0 = ok_cnt;
    m_ready = 1'b1;
    send_byte(8'h55, 1);
    pay = '{8'h7F};
    send_good_frame(1);
    check_drained("resync");
    tests_run++;
    if (ok_cnt - ok0 != 1) begin
      fails++;
      $display("FAIL resync_ok: got %0d frame_ok, want 1", ok_cnt - ok0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int ok0;
    m_ready = 1'b1;
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1); send_byte(8'h01, 0);
    while (frame_err !== 1'b1 && n < 6000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    // 5000 idle cycles after the last byte; allow one cycle of slack on either side.
    tests_run++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || n < 4999 || n > 5001) begin
      fails++;
      $display("FAIL timeout: got err=%b code=%0d after %0d idle cycles, want err=1 code=3 at ~5000",
               frame_err, err_code, n);
    end
    idle(2);
    ok0 = ok_cnt;
    pay = '{8'hC3, 8'h3C};
    send_good_frame(1);
    check_drained("after_timeout");
    tests_run++;
    if (ok_cnt - ok0 != 1 || err_code !== 2'd3) begin
      fails++;
      $display("FAIL after_timeout: got ok=%0d code=%0d, want 1 3", ok_cnt - ok0, err_code);
    end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt, b0 = beat_cnt;
    m_ready = 1'b0;
    pay = '{8'hA1, 8'hB2};
    send_good_frame(2);
    send_byte(8'h55, 0);
    tests_run++;
    if ({overrun, m_valid, m_data, m_last} !== {1'b1, 1'b1, 8'hA1, 1'b0}) begin
      fails++;
      $display("FAIL overrun_pulse: got ov=%b v=%b d=%h l=%b, want ov=1 v=1 d=a1 l=0",
               overrun, m_valid, m_data, m_last);
    end
    idle(1);
    tests_run++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_width: got overrun=%b, want 0", overrun);
    end
    m_ready = 1'b1;
    check_drained("overrun");
    tests_run++;
    if (ov_cnt - ov0 != 1 || beat_cnt - b0 != 2) begin
      fails++;
      $display("FAIL overrun_counts: got ov=%0d beats=%0d, want 1 2", ov_cnt - ov0, beat_cnt - b0);
    end
  endtask

  task automatic test_reset_mid();
    int ok0 = ok_cnt, err0 = err_cnt;
    m_ready = 1'b1;
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h04, 1);
    send_byte(8'h01, 1); send_byte(8'h02, 1);
    sys_rst = 1'b1;
    idle(1);
    tests_run++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, err_code, overrun} !== 15'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got v=%b d=%h l=%b ok=%b err=%b code=%0d ov=%b, want all 0",
               m_valid, m_data, m_last, frame_ok, frame_err, err_code, overrun);
    end
    sys_rst = 1'b0;
    idle(20);
    tests_run++;
    if (ok_cnt - ok0 != 0 || err_cnt - err0 != 0) begin
      fails++;
      $display("FAIL reset_mid_pulses: got ok=%0d err=%0d, want 0 0", ok_cnt - ok0, err_cnt - err0);
    end
    pay = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_good_frame(1);
    check_drained("reset_mid");
    tests_run++;
    if (ok_cnt - ok0 != 1) begin
      fails++;
      $display("FAIL reset_mid_recover: got %0d frame_ok, want 1", ok_cnt - ok0);
    end
  endtask

  task automatic test_back_to_back();
    int ok0 = ok_cnt, ov0 = ov_cnt, b0 = beat_cnt;
    m_ready = 1'b1;
    pay = '{8'h01};
    send_good_frame(1);
    pay = '{8'hFE, 8'h02, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h7E, 8'h55,
            8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77, 8'h99};
    send_good_frame(1);
    check_drained("b2b");
    tests_run++;
    if (ok_cnt - ok0 != 2 || ov_cnt - ov0 != 0 || beat_cnt - b0 != 17) begin
      fails++;
      $display("FAIL b2b_counts: got ok=%0d ov=%0d beats=%0d, want 2 0 17",
               ok_cnt - ok0, ov_cnt - ov0, beat_cnt - b0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_frames();
    test_resync();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
